// File: rtl/alu_pkg.sv
// Shared definitions for the ALU front end: FSM states, flag bit positions,
// the captured-flag payload and the opsel codes the requesters use most.
package alu_pkg;

    localparam int unsigned FLAGW = 4;

    // Bit positions inside a {C,Z,O,S} flag vector.
    localparam int unsigned FLAG_C = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_O = 1;
    localparam int unsigned FLAG_S = 0;

    // Arithmetic-mode (mode 0) operation selects.
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_e;

    // Captured flags; field order matches the FLAG_* positions.
    typedef struct packed {
        logic c;
        logic z;
        logic o;
        logic s;
    } flags_t;

endpackage

// File: rtl/alu_status_reg.sv
// Sticky flag accumulator and wrapping completed-operation counter.
//   capture_i : OR flags_i into the sticky register this cycle
//   clr_i     : clear the sticky register (a same-cycle capture still lands)
//   inc_i     : count one completed response
//   sticky_o  : accumulated {C,Z,O,S}
//   count_o   : completed responses, modulo 2^CNTW
module alu_status_reg
    import alu_pkg::*;
#(
    parameter int unsigned CNTW = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             capture_i,
    input  logic [FLAGW-1:0] flags_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [FLAGW-1:0] sticky_o,
    output logic [CNTW-1:0]  count_o
);

    logic [FLAGW-1:0] sticky_q, sticky_d;
    logic [CNTW-1:0]  count_q, count_d;

    // The clear acts on the old value, so a coincident capture survives it.
    always_comb begin
        sticky_d = clr_i ? '0 : sticky_q;
        count_d  = count_q;
        if (capture_i) begin
            sticky_d = sticky_d | flags_i;
        end
        if (inc_i) begin
            count_d = count_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= '0;
            count_q  <= '0;
        end else begin
            sticky_q <= sticky_d;
            count_q  <= count_d;
        end
    end

    assign sticky_o = sticky_q;
    assign count_o  = count_q;

endmodule

// File: rtl/alu_op_sequencer.sv
// Initiator-side front end for the ripple ALU: accepts a request, drives
// registered operands for one settle cycle, captures result and flags, and
// returns them with the request tag. Also exposes sticky flags and a
// completed-operation counter.
//   req_*   : valid/ready request channel (operands, opsel, mode, tag)
//   alu_*   : registered ALU inputs out, combinational result/flags back
//   resp_*  : valid/ready response channel (result, {C,Z,O,S}, tag)
//   sticky_flags / sticky_clr / op_count : status path
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned TAGW   = 4,
    parameter int unsigned CNTW   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DWIDTH-1:0] req_op1,
    input  logic [DWIDTH-1:0] req_op2,
    input  logic [2:0]        req_opsel,
    input  logic              req_mode,
    input  logic [TAGW-1:0]   req_tag,
    output logic [DWIDTH-1:0] alu_op1,
    output logic [DWIDTH-1:0] alu_op2,
    output logic [2:0]        alu_opsel,
    output logic              alu_mode,
    input  logic [DWIDTH-1:0] alu_result,
    input  logic              alu_c_flag,
    input  logic              alu_z_flag,
    input  logic              alu_o_flag,
    input  logic              alu_s_flag,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DWIDTH-1:0] resp_result,
    output logic [FLAGW-1:0]  resp_flags,
    output logic [TAGW-1:0]   resp_tag,
    output logic [FLAGW-1:0]  sticky_flags,
    input  logic              sticky_clr,
    output logic [CNTW-1:0]   op_count
);

    state_e state_q, state_d;
    logic   load_c, capture_c, handshake_c;
    flags_t flags_in_c;

    logic [DWIDTH-1:0] alu_op1_q, alu_op2_q, resp_result_q;
    logic [2:0]        alu_opsel_q;
    logic              alu_mode_q;
    logic [TAGW-1:0]   tag_q, resp_tag_q;
    logic [FLAGW-1:0]  resp_flags_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // RESP reuses the response handshake as the request accept so a new
    // operation can start in the same cycle the previous one retires.
    always_comb begin
        state_d    = state_q;
        load_c     = 1'b0;
        capture_c  = 1'b0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    load_c  = 1'b1;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                capture_c = 1'b1;
                state_d   = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                req_ready  = resp_ready;
                if (resp_ready) begin
                    if (req_valid) begin
                        load_c  = 1'b1;
                        state_d = DRIVE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign handshake_c = resp_valid && resp_ready;
    assign flags_in_c  = '{c: alu_c_flag, z: alu_z_flag, o: alu_o_flag, s: alu_s_flag};

    // ALU drive registers hold their last load; no return to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op1_q   <= '0;
            alu_op2_q   <= '0;
            alu_opsel_q <= '0;
            alu_mode_q  <= 1'b0;
            tag_q       <= '0;
        end else if (load_c) begin
            alu_op1_q   <= req_op1;
            alu_op2_q   <= req_op2;
            alu_opsel_q <= req_opsel;
            alu_mode_q  <= req_mode;
            tag_q       <= req_tag;
        end
    end

    // Response registers only change on the DRIVE->RESP edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_result_q <= '0;
            resp_flags_q  <= '0;
            resp_tag_q    <= '0;
        end else if (capture_c) begin
            resp_result_q <= alu_result;
            resp_flags_q  <= flags_in_c;
            resp_tag_q    <= tag_q;
        end
    end

    alu_status_reg #(
        .CNTW(CNTW)
    ) u_status (
        .clk       (clk),
        .rst_n     (rst_n),
        .capture_i (capture_c),
        .flags_i   (flags_in_c),
        .clr_i     (sticky_clr),
        .inc_i     (handshake_c),
        .sticky_o  (sticky_flags),
        .count_o   (op_count)
    );

    assign alu_op1     = alu_op1_q;
    assign alu_op2     = alu_op2_q;
    assign alu_opsel   = alu_opsel_q;
    assign alu_mode    = alu_mode_q;
    assign resp_result = resp_result_q;
    assign resp_flags  = resp_flags_q;
    assign resp_tag    = resp_tag_q;

endmodule
